sm4_out_collect: RTL

- Output-side counterpart of the SM4 round-input selector.
- Consumes the per-round 128-bit state from the SM4 round datapath, tagged with the same 6-bit round index `sm4_enc`, and checks that rounds arrive in order.
- After the final round it applies the SM4 reverse transform R and queues the ciphertext/plaintext block in a small output buffer.
- Hands blocks to the core/accelerator wrapper through a valid/ready handshake.

---
 rtl/sm4_out_collect_if.sv | 47 ++++
 rtl/sm4_out_collect.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sm4_out_collect_if.sv
// -----------------------------------------------------------------------------
// sm4_out_collect_if
//
// Purpose:
//   Bundles the two handshakes of the SM4 output collector.
//   - Round side: the SM4 round datapath presents one 128-bit state per cycle,
//     tagged with its round index.
//   - Block side: finished (reverse-transformed) blocks go to the
//     core/accelerator wrapper.
//   It also carries the collector status flags.
//
// Signals:
//   round_valid     round datapath -> collector  state/index valid this cycle
//   sm4_enc[5:0]    round datapath -> collector  round index of the state
//   data_transform  round datapath -> collector  state after round sm4_enc
//   round_ready     collector -> round datapath  round accepted this cycle
//   out_valid       collector -> consumer        buffer head holds a block
//   out_ready       consumer  -> collector       consumer takes the head
//   cipher_out      collector -> consumer        buffer head value
//   busy            collector -> wrapper         a block is partially collected
//   round_err       collector -> wrapper         pulse on an out-of-order round
//
// Modports:
//   master : environment side (round datapath plus consumer)
//   slave  : the collector itself
// -----------------------------------------------------------------------------
interface sm4_out_collect_if;
  logic         round_valid;
  logic [5:0]   sm4_enc;
  logic [127:0] data_transform;
  logic         round_ready;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] cipher_out;
  logic         busy;
  logic         round_err;

  modport master (
    output round_valid, sm4_enc, data_transform, out_ready,
    input  round_ready, out_valid, cipher_out, busy, round_err
  );

  modport slave (
    input  round_valid, sm4_enc, data_transform, out_ready,
    output round_ready, out_valid, cipher_out, busy, round_err
  );
endinterface

// File: rtl/sm4_out_collect.sv
// -----------------------------------------------------------------------------
// sm4_out_collect
//
// Purpose:
//   This is the output-side counterpart of the SM4 round-input selector.
//   - It tracks the expected round index (exp_rnd) and checks that the round
//     states arrive in order.
//   - When the final round arrives in order, it applies the SM4 reverse
//     transform R (a word swap) to that state.
//   - It then queues the result in a small circular FIFO, which drains
//     through a valid/ready handshake.
//
// Parameters:
//   NUM_ROUNDS  rounds per block (2..63); the last round index is NUM_ROUNDS-1
//   DEPTH       output buffer entries (1..4)
//
// Ports:
//   clk   rising-edge clock for all state
//   rest  synchronous active-high reset
//   bus   sm4_out_collect_if.slave (round handshake, block handshake, status)
//
// Behaviour notes:
//   - round_ready drops only while the final round is due and the buffer is
//     full.
//   - round_ready is computed from next-state values and registered, so
//     out_ready has no combinational path to it. A pop therefore frees space
//     one cycle later.
//   - cipher_out is a register that mirrors the next buffer head.
//     - A push into an empty buffer is visible the cycle after the final round.
//     - When the buffer drains, cipher_out keeps the last popped value.
// -----------------------------------------------------------------------------
module sm4_out_collect #(
  parameter int NUM_ROUNDS = 32,
  parameter int DEPTH      = 2
) (
  input  logic           clk,
  input  logic           rest,
  sm4_out_collect_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [5:0]       LAST_RND = 6'(NUM_ROUNDS - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // Coarse view of exp_rnd: zero, somewhere mid-block, or final round due.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FINAL   = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e             r_state;
  logic [5:0]         r_exp_rnd;
  logic [127:0]       r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [127:0]       r_cipher;
  logic               r_round_ready;
  logic               r_busy;
  logic               r_round_err;

  // ---------------------------------------------------------------------------
  // Combinational next-state
  // ---------------------------------------------------------------------------
  logic               w_accept;
  logic               w_in_order;
  logic               w_push;
  logic               w_pop;
  logic               w_err;
  logic [5:0]         w_exp_next;
  state_e             w_state_next;
  logic [PTR_W-1:0]   w_wr_next;
  logic [PTR_W-1:0]   w_rd_next;
  logic [CNT_W-1:0]   w_count_next;
  logic [127:0]       w_rev;
  logic [127:0]       w_head_next;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Reverse transform R: reverse the order of the four 32-bit words.
  assign w_rev = {bus.data_transform[31:0],  bus.data_transform[63:32],
                  bus.data_transform[95:64], bus.data_transform[127:96]};

  assign w_accept   = bus.round_valid & r_round_ready;
  assign w_in_order = (bus.sm4_enc == r_exp_rnd);
  assign w_push     = w_accept & w_in_order & (r_state == ST_FINAL);
  assign w_pop      = (r_count != '0) & bus.out_ready;

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_exp_next = r_exp_rnd;
    w_err      = 1'b0;
    if (w_accept) begin
      if (w_in_order) begin
        w_exp_next = (r_exp_rnd == LAST_RND) ? 6'd0 : r_exp_rnd + 6'd1;
      end else begin
        w_err = 1'b1;
        // A stray round 0 starts a new block; any other stray round aborts.
        w_exp_next = (bus.sm4_enc == 6'd0) ? 6'd1 : 6'd0;
      end
    end
  end

  always_comb begin
    if (w_exp_next == 6'd0)           w_state_next = ST_IDLE;
    else if (w_exp_next == LAST_RND)  w_state_next = ST_FINAL;
    else                              w_state_next = ST_COLLECT;
  end

  assign w_wr_next = w_push ? ptr_inc(r_wr_ptr) : r_wr_ptr;
  assign w_rd_next = w_pop  ? ptr_inc(r_rd_ptr) : r_rd_ptr;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // The entry being written this cycle is not in r_mem yet. Forward it when it
  // becomes the new head, which happens for a push into an empty buffer or for
  // a push and pop together with one entry held.
  assign w_head_next = (w_push && (w_rd_next == r_wr_ptr)) ? w_rev : r_mem[w_rd_next];

  // ---------------------------------------------------------------------------
  // Control and status state
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the values from before the edge, whatever the
  // order of the statements.
  always_ff @(posedge clk) begin
    if (rest) begin
      r_state       <= ST_IDLE;
      r_exp_rnd     <= 6'd0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_cipher      <= '0;
      r_round_ready <= 1'b1;
      r_busy        <= 1'b0;
      r_round_err   <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_exp_rnd     <= w_exp_next;
      r_wr_ptr      <= w_wr_next;
      r_rd_ptr      <= w_rd_next;
      r_count       <= w_count_next;
      r_round_err   <= w_err;
      r_busy        <= (w_exp_next != 6'd0);
      r_round_ready <= !((w_state_next == ST_FINAL) && (w_count_next == CNT_FULL));
      if (w_count_next != '0) begin
        r_cipher <= w_head_next;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Buffer storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset. The count and pointers decide which
  // entries are valid, and r_cipher loads an entry only when the buffer is
  // non-empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_rev;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.round_ready = r_round_ready;
  assign bus.out_valid   = (r_count != '0);
  assign bus.cipher_out  = r_cipher;
  assign bus.busy        = r_busy;
  assign bus.round_err   = r_round_err;

endmodule
